// File: rtl/ebox_mem_seq.sv
// EBOX memory reference sequencer: issues read/write/PSE requests to the MBOX and handles retries and errors.
// Optional watchdog enabled by defining EBOX_MEM_TIMEOUT_EN.
module ebox_mem_seq #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 7
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         startRead,
  input  logic         startWrite,
  input  logic         startPSE,
  input  logic [13:35] vmaIn,
  input  logic         cshEBOXT0,
  input  logic         cshEBOXRetry,
  input  logic         mboxRespIn,
  input  logic [0:35]  cacheData,
  input  logic [0:4]   errIn,
  input  logic         clrErr,
  output logic         eboxReq,
  output logic         eboxRead,
  output logic         eboxWrite,
  output logic         eboxPSE,
  output logic [13:35] eboxVMA,
  output logic         memBusy,
  output logic         memDone,
  output logic [0:35]  dataOut,
  output logic         anyEboxError,
  output logic [0:2]   errCode
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RETRY = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  localparam logic [0:2] ERR_NONE  = 3'd0;
  localparam logic [0:2] ERR_IN    = 3'd1;
  localparam logic [0:2] ERR_RETRY = 3'd2;
  localparam logic [0:2] ERR_TMO   = 3'd3;

  // The 3-bit count wraps, so overflow is judged on the widened increment.
  function automatic logic retry_over(input logic [2:0] cnt);
    logic [3:0] inc;
    inc = {1'b0, cnt} + 4'd1;
    return (32'(inc) > MAX_RETRY);
  endfunction

  logic [2:0] state_r;
  logic [2:0] state_nxt_s;
  logic [2:0] retry_cnt_r;
  logic [2:0] retry_cnt_nxt_s;
  logic       retry_ovf_r;
  logic       retry_ovf_nxt_s;
  logic [0:2] err_code_nxt_s;
  logic       load_data_s;
  logic       tmo_hit_s;
  logic       start_any_s;
  logic       err_any_s;

  assign start_any_s = startRead | startWrite | startPSE;
  assign err_any_s   = |errIn;

`ifdef EBOX_MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wdog_r;

  // Watchdog counts consecutive cycles spent in REQ or WAIT.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wdog_r <= 8'd0;
    end else if (state_r == ST_REQ || state_r == ST_WAIT) begin
      wdog_r <= wdog_r + 8'd1;
    end else begin
      wdog_r <= 8'd0;
    end
  end

  assign tmo_hit_s = (wdog_r == TMO_LAST);
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^32'(TIMEOUT);
  assign tmo_hit_s        = 1'b0;
`endif

  // Next-state, retry bookkeeping and error code selection.
  always_comb begin
    state_nxt_s     = state_r;
    retry_cnt_nxt_s = retry_cnt_r;
    retry_ovf_nxt_s = retry_ovf_r;
    err_code_nxt_s  = errCode;
    load_data_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_any_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ, ST_WAIT: begin
        if (err_any_s) begin
          state_nxt_s    = ST_ERROR;
          err_code_nxt_s = ERR_IN;
        end else if (cshEBOXRetry) begin
          state_nxt_s     = ST_RETRY;
          retry_cnt_nxt_s = retry_cnt_r + 3'd1;
          retry_ovf_nxt_s = retry_over(retry_cnt_r);
        end else if (tmo_hit_s) begin
          state_nxt_s    = ST_ERROR;
          err_code_nxt_s = ERR_TMO;
        end else if (state_r == ST_REQ && cshEBOXT0) begin
          state_nxt_s = ST_WAIT;
        end else if (state_r == ST_WAIT && mboxRespIn) begin
          state_nxt_s = ST_DONE;
          load_data_s = eboxRead | eboxPSE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RETRY: begin
        if (err_any_s) begin
          state_nxt_s    = ST_ERROR;
          err_code_nxt_s = ERR_IN;
        end else if (retry_ovf_r) begin
          state_nxt_s    = ST_ERROR;
          err_code_nxt_s = ERR_RETRY;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DONE: begin
        retry_cnt_nxt_s = 3'd0;
        retry_ovf_nxt_s = 1'b0;
        if (err_any_s) begin
          state_nxt_s    = ST_ERROR;
          err_code_nxt_s = ERR_IN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (err_any_s) begin
          state_nxt_s    = ST_ERROR;
          err_code_nxt_s = ERR_IN;
        end else if (clrErr) begin
          state_nxt_s     = ST_IDLE;
          err_code_nxt_s  = ERR_NONE;
          retry_cnt_nxt_s = 3'd0;
          retry_ovf_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_ERROR;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        err_code_nxt_s  = ERR_NONE;
        retry_cnt_nxt_s = 3'd0;
        retry_ovf_nxt_s = 1'b0;
      end
    endcase
  end

  // State, registered status outputs, command latch and read data capture.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r      <= ST_IDLE;
      retry_cnt_r  <= 3'd0;
      retry_ovf_r  <= 1'b0;
      errCode      <= ERR_NONE;
      eboxReq      <= 1'b0;
      memBusy      <= 1'b0;
      memDone      <= 1'b0;
      anyEboxError <= 1'b0;
      eboxRead     <= 1'b0;
      eboxWrite    <= 1'b0;
      eboxPSE      <= 1'b0;
      eboxVMA      <= 23'd0;
      dataOut      <= 36'd0;
    end else begin
      state_r      <= state_nxt_s;
      retry_cnt_r  <= retry_cnt_nxt_s;
      retry_ovf_r  <= retry_ovf_nxt_s;
      errCode      <= err_code_nxt_s;
      eboxReq      <= (state_nxt_s == ST_REQ);
      memBusy      <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
      memDone      <= (state_nxt_s == ST_DONE);
      anyEboxError <= (state_nxt_s == ST_ERROR);
      // Command priority on simultaneous starts: write, then PSE, then read.
      if (state_r == ST_IDLE && start_any_s) begin
        eboxWrite <= startWrite;
        eboxPSE   <= ~startWrite & startPSE;
        eboxRead  <= ~startWrite & ~startPSE & startRead;
        eboxVMA   <= vmaIn;
      end else if (state_nxt_s == ST_IDLE) begin
        eboxWrite <= 1'b0;
        eboxPSE   <= 1'b0;
        eboxRead  <= 1'b0;
        eboxVMA   <= 23'd0;
      end
      if (load_data_s) begin
        dataOut <= cacheData;
      end
    end
  end

endmodule

// File: tb/tb_ebox_mem_seq.sv
// Directed, table-driven bench for ebox_mem_seq plus hand-written retry, error, timeout and reset sequences.
module tb_ebox_mem_seq;

  logic         clk;
  logic         resetN;
  logic         startRead, startWrite, startPSE;
  logic [13:35] vmaIn;
  logic         cshEBOXT0, cshEBOXRetry, mboxRespIn;
  logic [0:35]  cacheData;
  logic [0:4]   errIn;
  logic         clrErr;
  logic         eboxReq, eboxRead, eboxWrite, eboxPSE;
  logic [13:35] eboxVMA;
  logic         memBusy, memDone;
  logic [0:35]  dataOut;
  logic         anyEboxError;
  logic [0:2]   errCode;

  int n_tests = 0;
  int n_fail  = 0;

  ebox_mem_seq #(.TIMEOUT(16), .MAX_RETRY(7)) dut (
    .clk(clk), .resetN(resetN),
    .startRead(startRead), .startWrite(startWrite), .startPSE(startPSE),
    .vmaIn(vmaIn), .cshEBOXT0(cshEBOXT0), .cshEBOXRetry(cshEBOXRetry),
    .mboxRespIn(mboxRespIn), .cacheData(cacheData), .errIn(errIn), .clrErr(clrErr),
    .eboxReq(eboxReq), .eboxRead(eboxRead), .eboxWrite(eboxWrite), .eboxPSE(eboxPSE),
    .eboxVMA(eboxVMA), .memBusy(memBusy), .memDone(memDone), .dataOut(dataOut),
    .anyEboxError(anyEboxError), .errCode(errCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [0:4]   E0  = 5'b00000;
  localparam logic [0:4]   NXM = 5'b00010;
  localparam logic [13:35] VA  = 23'o1234;
  localparam logic [13:35] VB  = 23'o7777;
  localparam logic [13:35] VC  = 23'o55;
  localparam logic [13:35] VD  = 23'o3;
  localparam logic [13:35] V0  = 23'd0;
  localparam logic [0:35]  D0  = 36'd0;
  localparam logic [0:35]  D1  = 36'o123456701234;
  localparam logic [0:35]  D2  = 36'o777;
  localparam logic [0:35]  D3  = 36'o42;
  localparam logic [0:35]  D4  = 36'o3333;

  typedef struct {
    logic         sr, sw, sp, t0, rt, rsp, clr;
    logic [0:4]   err;
    logic [13:35] vma;
    logic [0:35]  data;
    logic [9:0]   exp_ctl;
    logic [13:35] exp_vma;
    logic [0:35]  exp_dout;
  } vec_t;

  vec_t tbl[22];

  // {eboxReq, eboxRead, eboxWrite, eboxPSE, memBusy, memDone, anyEboxError, errCode}
  function automatic logic [9:0] ctl(input logic req, rd, wr, pse, busy, done, any,
                                     input logic [2:0] code);
    return {req, rd, wr, pse, busy, done, any, code};
  endfunction

  function automatic logic [9:0] ctl_now();
    return {eboxReq, eboxRead, eboxWrite, eboxPSE, memBusy, memDone, anyEboxError, errCode};
  endfunction

  function automatic vec_t mk(input logic sr, sw, sp, t0, rt, rsp, clr, input logic [0:4] err,
                              input logic [13:35] vma, input logic [0:35] data,
                              input logic [9:0] ec, input logic [13:35] ev, input logic [0:35] ed);
    vec_t v;
    v.sr = sr; v.sw = sw; v.sp = sp; v.t0 = t0; v.rt = rt; v.rsp = rsp; v.clr = clr;
    v.err = err; v.vma = vma; v.data = data;
    v.exp_ctl = ec; v.exp_vma = ev; v.exp_dout = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    startRead = 1'b0; startWrite = 1'b0; startPSE = 1'b0;
    cshEBOXT0 = 1'b0; cshEBOXRetry = 1'b0; mboxRespIn = 1'b0;
    errIn = 5'd0; clrErr = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    startRead = v.sr; startWrite = v.sw; startPSE = v.sp;
    cshEBOXT0 = v.t0; cshEBOXRetry = v.rt; mboxRespIn = v.rsp;
    clrErr = v.clr; errIn = v.err; vmaIn = v.vma; cacheData = v.data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    resetN = 1'b0;
    startRead = 1'b0; startWrite = 1'b0; startPSE = 1'b0;
    cshEBOXT0 = 1'b0; cshEBOXRetry = 1'b0; mboxRespIn = 1'b0;
    errIn = 5'd0; clrErr = 1'b0; vmaIn = 23'd0; cacheData = 36'd0;

    //            sr sw sp t0 rt rsp clr err  vma data  expected ctl                        vma dout
    tbl[0]  = mk(Y, N, N, N, N, N, N, E0,  VA, D0, ctl(Y, Y, N, N, Y, N, N, 3'd0), VA, D0);
    tbl[1]  = mk(N, N, N, N, N, N, N, E0,  VA, D0, ctl(Y, Y, N, N, Y, N, N, 3'd0), VA, D0);
    tbl[2]  = mk(N, N, N, Y, N, N, N, E0,  V0, D0, ctl(N, Y, N, N, Y, N, N, 3'd0), VA, D0);
    tbl[3]  = mk(N, Y, N, N, N, N, N, E0,  VB, D0, ctl(N, Y, N, N, Y, N, N, 3'd0), VA, D0);
    tbl[4]  = mk(N, N, N, N, N, N, N, E0,  V0, D0, ctl(N, Y, N, N, Y, N, N, 3'd0), VA, D0);
    tbl[5]  = mk(N, N, N, N, N, Y, N, E0,  V0, D1, ctl(N, Y, N, N, N, Y, N, 3'd0), VA, D1);
    tbl[6]  = mk(N, N, N, N, N, N, N, E0,  V0, D0, ctl(N, N, N, N, N, N, N, 3'd0), V0, D1);
    tbl[7]  = mk(N, N, N, Y, Y, Y, N, E0,  V0, D2, ctl(N, N, N, N, N, N, N, 3'd0), V0, D1);
    tbl[8]  = mk(Y, Y, Y, N, N, N, N, E0,  VB, D0, ctl(Y, N, Y, N, Y, N, N, 3'd0), VB, D1);
    tbl[9]  = mk(N, N, N, Y, N, N, N, E0,  V0, D0, ctl(N, N, Y, N, Y, N, N, 3'd0), VB, D1);
    tbl[10] = mk(N, N, N, N, N, Y, N, E0,  V0, D2, ctl(N, N, Y, N, N, Y, N, 3'd0), VB, D1);
    tbl[11] = mk(N, N, N, N, N, N, N, E0,  V0, D0, ctl(N, N, N, N, N, N, N, 3'd0), V0, D1);
    tbl[12] = mk(Y, N, Y, N, N, N, N, E0,  VC, D0, ctl(Y, N, N, Y, Y, N, N, 3'd0), VC, D1);
    tbl[13] = mk(N, N, N, Y, N, N, N, E0,  V0, D0, ctl(N, N, N, Y, Y, N, N, 3'd0), VC, D1);
    tbl[14] = mk(N, N, N, N, N, Y, N, E0,  V0, D3, ctl(N, N, N, Y, N, Y, N, 3'd0), VC, D3);
    tbl[15] = mk(Y, N, N, N, N, N, N, E0,  VA, D0, ctl(N, N, N, N, N, N, N, 3'd0), V0, D3);
    tbl[16] = mk(N, N, N, N, N, N, N, E0,  V0, D0, ctl(N, N, N, N, N, N, N, 3'd0), V0, D3);
    tbl[17] = mk(Y, N, N, N, N, N, N, E0,  VD, D0, ctl(Y, Y, N, N, Y, N, N, 3'd0), VD, D3);
    tbl[18] = mk(N, N, N, Y, N, N, N, E0,  V0, D0, ctl(N, Y, N, N, Y, N, N, 3'd0), VD, D3);
    tbl[19] = mk(N, N, N, N, N, Y, N, NXM, V0, D2, ctl(N, Y, N, N, Y, N, Y, 3'd1), VD, D3);
    tbl[20] = mk(N, N, N, N, N, N, N, E0,  V0, D0, ctl(N, Y, N, N, Y, N, Y, 3'd1), VD, D3);
    tbl[21] = mk(N, N, N, N, N, N, Y, E0,  V0, D0, ctl(N, N, N, N, N, N, N, 3'd0), V0, D3);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl",  64'(ctl_now()), 64'(10'd0));
    chk("reset_vma",  64'(eboxVMA),   64'(23'd0));
    chk("reset_dout", 64'(dataOut),   64'(36'd0));
    resetN = 1'b1;

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i]);
      tick();
      chk($sformatf("row%0d_ctl", i),  64'(ctl_now()), 64'(tbl[i].exp_ctl));
      chk($sformatf("row%0d_vma", i),  64'(eboxVMA),   64'(tbl[i].exp_vma));
      chk($sformatf("row%0d_dout", i), 64'(dataOut),   64'(tbl[i].exp_dout));
    end

    // Write with two retries during WAIT; each retry drops eboxReq for one cycle.
    startWrite = 1'b1; vmaIn = 23'o100; tick();
    for (int k = 0; k < 2; k++) begin
      cshEBOXT0 = 1'b1; tick();
      chk("wr_wait", 64'(ctl_now()), 64'(ctl(N, N, Y, N, Y, N, N, 3'd0)));
      cshEBOXRetry = 1'b1; tick();
      chk("wr_retry", 64'(ctl_now()), 64'(ctl(N, N, Y, N, Y, N, N, 3'd0)));
      tick();
      chk("wr_rereq", 64'(ctl_now()), 64'(ctl(Y, N, Y, N, Y, N, N, 3'd0)));
    end
    cshEBOXT0 = 1'b1; tick();
    mboxRespIn = 1'b1; cacheData = D2; tick();
    chk("wr_done", 64'(ctl_now()), 64'(ctl(N, N, Y, N, N, Y, N, 3'd0)));
    chk("wr_dout_hold", 64'(dataOut), 64'(D3));
    tick();

    // Seven retries on the next reference still complete: the count was cleared.
    startRead = 1'b1; vmaIn = 23'o200; tick();
    for (int k = 0; k < 7; k++) begin
      cshEBOXRetry = 1'b1; tick();
      chk("rd7_retry", 64'(ctl_now()), 64'(ctl(N, Y, N, N, Y, N, N, 3'd0)));
      tick();
      chk("rd7_rereq", 64'(ctl_now()), 64'(ctl(Y, Y, N, N, Y, N, N, 3'd0)));
    end
    cshEBOXT0 = 1'b1; tick();
    mboxRespIn = 1'b1; cacheData = D4; tick();
    chk("rd7_done", 64'(ctl_now()), 64'(ctl(N, Y, N, N, N, Y, N, 3'd0)));
    chk("rd7_dout", 64'(dataOut), 64'(D4));
    tick();

    // Eight retries overflow; the first also carries T0, which retry must win over.
    startRead = 1'b1; vmaIn = 23'o300; tick();
    for (int k = 0; k < 8; k++) begin
      cshEBOXRetry = 1'b1;
      cshEBOXT0 = (k == 0) ? 1'b1 : 1'b0;
      tick();
      chk("ovf_retry", 64'(ctl_now()), 64'(ctl(N, Y, N, N, Y, N, N, 3'd0)));
      tick();
      if (k < 7) begin
        chk("ovf_rereq", 64'(ctl_now()), 64'(ctl(Y, Y, N, N, Y, N, N, 3'd0)));
      end else begin
        chk("ovf_error", 64'(ctl_now()), 64'(ctl(N, Y, N, N, Y, N, Y, 3'd2)));
      end
    end
    clrErr = 1'b1; tick();
    chk("ovf_clr", 64'(ctl_now()), 64'(ctl(N, N, N, N, N, N, N, 3'd0)));

    // No T0: with the watchdog the reference errors 16 cycles after entering REQ.
    startRead = 1'b1; vmaIn = 23'o400; tick();
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("tmo_pending", 64'(ctl_now()), 64'(ctl(Y, Y, N, N, Y, N, N, 3'd0)));
    end
    tick();
`ifdef EBOX_MEM_TIMEOUT_EN
    chk("tmo_error", 64'(ctl_now()), 64'(ctl(N, Y, N, N, Y, N, Y, 3'd3)));
    clrErr = 1'b1; tick();
`else
    chk("tmo_absent", 64'(ctl_now()), 64'(ctl(Y, Y, N, N, Y, N, N, 3'd0)));
    cshEBOXT0 = 1'b1; tick();
    mboxRespIn = 1'b1; cacheData = D3; tick();
    tick();
`endif
    chk("tmo_recover", 64'(ctl_now()), 64'(ctl(N, N, N, N, N, N, N, 3'd0)));

    // Reset mid-WAIT clears everything at once; a later response is ignored.
    startRead = 1'b1; vmaIn = 23'o2; tick();
    cshEBOXT0 = 1'b1; tick();
    chk("rst_wait", 64'(ctl_now()), 64'(ctl(N, Y, N, N, Y, N, N, 3'd0)));
    #2 resetN = 1'b0;
    #1;
    chk("rst_async_ctl",  64'(ctl_now()), 64'(10'd0));
    chk("rst_async_vma",  64'(eboxVMA),   64'(23'd0));
    chk("rst_async_dout", 64'(dataOut),   64'(36'd0));
    tick();
    resetN = 1'b1;
    mboxRespIn = 1'b1; cacheData = D1; tick();
    chk("rst_resp_ctl",  64'(ctl_now()), 64'(10'd0));
    chk("rst_resp_dout", 64'(dataOut),   64'(36'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ebox_mem_seq.md
EBOX_MEM_SEQ -- requirements
Module: ebox_mem_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of cycles in REQ+WAIT before a timeout error.
REQ-002 SHALL have parameter MAX_RETRY, default 7, meaning the number of cshEBOXRetry events tolerated per reference.
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on its rising edge.
- resetN  in  1  asynchronous, active-low reset.
- startRead  in  1  one-cycle pulse: begin a read reference.
- startWrite  in  1  one-cycle pulse: begin a write reference.
- startPSE  in  1  one-cycle pulse: begin a paged-store-enable (read-pause-write) reference.
- vmaIn  in  [13:35]  virtual address for the reference.
- cshEBOXT0  in  1  MBOX accepted the request.
- cshEBOXRetry  in  1  MBOX demands a retry.
- mboxRespIn  in  1  MBOX completed the reference.
- cacheData  in  [0:35]  read data, valid with mboxRespIn.
- errIn  in  [0:4]  {cshAdrParErr, mbParErr, sbusErr, nxmErr, mboxCDirParErr}.
- clrErr  in  1  one-cycle pulse: clear the error state.
- eboxReq  out  1  request to MBOX.
- eboxRead, eboxWrite, eboxPSE  out  1 each  latched command qualifiers.
- eboxVMA  out  [13:35]  latched address.
- memBusy  out  1  microcode clock holdoff.
- memDone  out  1  one-cycle completion pulse.
- dataOut  out  [0:35]  captured read data.
- anyEboxError  out  1  sticky error flag.
- errCode  out  [0:2]  0 none, 1 errIn, 2 retry overflow, 3 timeout.

Function
REQ-004 SHALL implement the states IDLE, REQ, WAIT, RETRY, DONE and ERROR, encoded in registers.
REQ-005 IDLE: on any start pulse, SHALL latch vmaIn and the command, and enter REQ on the next edge. If more than one start is asserted, priority is write > PSE > read.
REQ-006 Start pulses outside IDLE SHALL be ignored with no state change.
REQ-007 eboxReq SHALL be 1 exactly while in REQ. eboxRead, eboxWrite, eboxPSE and eboxVMA SHALL hold their latched values from acceptance until the return to IDLE.
REQ-008 REQ: cshEBOXT0 SHALL move the FSM to WAIT.
REQ-009 REQ or WAIT: cshEBOXRetry SHALL move the FSM to RETRY and increment the 3-bit retry count. Retry wins over a same-cycle cshEBOXT0 or mboxRespIn.
REQ-010 RETRY SHALL last exactly one cycle with eboxReq=0, then go to REQ. If the incremented count exceeds MAX_RETRY, it SHALL go to ERROR with errCode=2 instead.
REQ-011 WAIT: mboxRespIn SHALL move the FSM to DONE. For a read or PSE, dataOut SHALL load cacheData on that same edge; for a write, dataOut SHALL hold its value.
REQ-012 DONE SHALL assert memDone for one cycle, clear the retry count, and return to IDLE.
REQ-013 memBusy SHALL be 1 in every state except IDLE and DONE. Latency from start to memDone is 3 cycles plus the MBOX delay.
REQ-014 Any errIn bit set while not in IDLE SHALL move the FSM to ERROR with errCode=1. This has priority over all other events in the same cycle.
REQ-015 ERROR SHALL set anyEboxError and keep memBusy=1 and eboxReq=0. clrErr SHALL return the FSM to IDLE and clear anyEboxError, errCode and the retry count.
REQ-016 mboxRespIn, cshEBOXT0 and cshEBOXRetry SHALL be ignored in IDLE, DONE and ERROR.

Reset
REQ-017 With resetN=0, the FSM SHALL enter IDLE immediately, regardless of state.
REQ-018 Reset values: all outputs 0, the retry count 0, and the timeout counter 0. A reference in flight SHALL be abandoned with no memDone.

Configuration
REQ-019 Macro EBOX_MEM_TIMEOUT_EN, when defined, SHALL include an 8-bit watchdog with the following behaviour:
- It increments each cycle in REQ or WAIT.
- It clears in RETRY, DONE and IDLE.
- On reaching TIMEOUT, the FSM SHALL go to ERROR with errCode=3.
REQ-020 When EBOX_MEM_TIMEOUT_EN is undefined, the watchdog SHALL be absent and errCode=3 SHALL never occur.

Verification
REQ-021 Read of vmaIn=0o1234: T0 arrives 2 cycles after eboxReq rises, and mboxRespIn arrives 3 cycles later with cacheData=0o123456701234 -> memDone pulses once, dataOut=0o123456701234, and memBusy falls in the memDone cycle.
REQ-022 Write with cshEBOXRetry asserted twice during WAIT -> eboxReq drops for one cycle each time, and the reference completes with the retry count returning to 0.
REQ-023 Eight consecutive retries with MAX_RETRY=7 -> ERROR, anyEboxError=1, errCode=2; clrErr -> IDLE.
REQ-024 nxmErr and mboxRespIn in the same WAIT cycle -> ERROR with errCode=1, and no memDone pulse.
REQ-025 With EBOX_MEM_TIMEOUT_EN defined and TIMEOUT=16, and no T0 -> ERROR with errCode=3 exactly 16 cycles after entering REQ; with the macro undefined -> the FSM remains in REQ.
REQ-026 resetN asserted mid-WAIT -> all outputs 0 immediately; a later mboxRespIn is ignored.
